// File: rtl/risc_ctrl_pkg.sv
// risc_ctrl_pkg
// Shared encodings for the RISC control units (single-cycle and multi-cycle):
// multi-cycle FSM state codes, opcode constants, datapath mux/ALU select codes
// and the packed control-word struct that the multi-cycle decoder produces.
// No ports (package).
package risc_ctrl_pkg;

  // Multi-cycle FSM state codes; 11..15 are unused and recover to IDLE.
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_EXEC     = 4'd7;
  localparam logic [3:0] S_R_DONE   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;

  // Opcodes (IR[31:26]).
  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_J      = 6'b000010;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_e;

  // Full set of datapath strobes/selects driven by the multi-cycle controller.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_source_e pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if
// Bundle between the multi-cycle controller and the datapath/memory.
//   Datapath -> controller: opcode[5:0], zero, mem_ready
//   Controller -> datapath: pc_write, pc_write_cond, i_or_d, mem_read,
//     mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
//     alu_src_b[1:0], alu_op[1:0], pc_source[1:0], instr_done, illegal_op,
//     state[3:0] (debug)
// Modports: master = controller side, slave = datapath side.
interface multicycle_ctrl_fsm_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode
// Purely combinational decode of the controller state (plus mem_ready for the
// few handshake-qualified strobes) into the datapath control word.
//   state_i[3:0]  current FSM state
//   mem_ready_i   memory completed the current access this cycle
//   ctrl_o        control word (risc_ctrl_pkg::ctrl_t)
// Config macro: RISC_JUMP_EN (decode of the JUMP state).
module multicycle_ctrl_decode
  import risc_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        // PC+4 computed while the instruction is read; IR and PC only
        // update in the cycle the memory actually returns data.
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        // Branch target precompute into ALUOut.
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_DONE: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.instr_done    = 1'b1;
      end
`ifdef RISC_JUMP_EN
      S_JUMP: begin
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
`endif
      default: ;  // IDLE and unused codes: everything inactive
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
// Sequencing controller for the multi-cycle RISC datapath. Steps the shared
// memory port / ALU / register file through FETCH, DECODE, execute, memory
// and write-back states, holding in memory states until mem_ready.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (state -> IDLE, outputs inactive)
//   bus    multicycle_ctrl_fsm_if.master: opcode/zero/mem_ready in,
//          all control strobes, illegal_op and debug state out
// Config macro: RISC_JUMP_EN -- when defined, opcode 000010 runs the JUMP
// state; when undefined it is treated as illegal and code 10 is unused.
module multicycle_ctrl_fsm
  import risc_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_ctrl_fsm_if.master  bus
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       illegal;
  ctrl_t      ctrl;

  // Next-state logic. opcode is only looked at in DECODE and MEM_ADDR.
  always_comb begin
    state_d = S_IDLE;
    illegal = 1'b0;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_R_TYPE:    state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef RISC_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      // Only lw/sw reach here; anything that is not a store is run as a load.
      S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC:     state_d = S_R_DONE;
      S_R_DONE:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
`ifdef RISC_JUMP_EN
      S_JUMP:     state_d = S_FETCH;
`endif
      default:    state_d = S_IDLE;  // unused codes recover
    endcase
  end

  // Asynchronous reset forces IDLE immediately, so the decoded strobes drop
  // in the same cycle and an in-flight instruction is abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  multicycle_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.instr_done    = ctrl.instr_done;
  assign bus.illegal_op    = illegal;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. Each cycle's expected state and
// full output vector is pushed to a scoreboard queue as stimulus is planned,
// then popped and compared as the DUT steps through the cycle.
module tb_multicycle_ctrl_fsm;
  import risc_ctrl_pkg::*;

`ifdef RISC_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  localparam logic [5:0] OP_JUNK = 6'b111111;  // noise on opcode where it must be ignored
  localparam logic [5:0] OP_BAD  = 6'b000110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic        mr;
    logic [5:0]  op;
    logic [21:0] exp;
  } cyc_t;

  cyc_t sb[$];
  int tests = 0;
  int fails = 0;

  // Reference behaviour written from the state/output table:
  // {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
  //  instr_done, illegal_op}
  function automatic logic [21:0] model(input logic [3:0] st, input logic mr,
                                        input logic [5:0] op);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, done, ill;
    logic [1:0] asb, aop, pcs;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, done, ill} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      4'd1: begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
      4'd2: begin
        asb = 2'b11;
        ill = !(op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
                op == 6'b000100 || (JUMP_EN && op == 6'b000010));
      end
      4'd3: begin asa = 1'b1; asb = 2'b10; end
      4'd4: begin mrd = 1'b1; iod = 1'b1; end
      4'd5: begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
      4'd6: begin mwr = 1'b1; iod = 1'b1; done = mr; end
      4'd7: begin asa = 1'b1; aop = 2'b10; end
      4'd8: begin rw = 1'b1; rdst = 1'b1; done = 1'b1; end
      4'd9: begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; pwc = 1'b1; done = 1'b1; end
      4'd10: begin pcs = 2'b10; pw = 1'b1; done = 1'b1; end
      default: ;
    endcase
    return {st, pw, pwc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, done, ill};
  endfunction

  function automatic logic [21:0] observed();
    return {bus.state, bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
            bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
            bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source,
            bus.instr_done, bus.illegal_op};
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic [5:0] op);
    cyc_t c;
    c.st = st; c.mr = mr; c.op = op; c.exp = model(st, mr, op);
    sb.push_back(c);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      tests++;
      if (observed() !== 22'd0) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, observed(), 22'd0);
      end
    end
    @(negedge clk); rst_n = 1'b1; #1;
    tests++;
    if (observed() !== 22'd0) begin
      fails++;
      $display("FAIL reset_release_idle got=%h want=%h", observed(), 22'd0);
    end
  endtask

  task automatic test_rtype();
    cyc_t c;
    push(S_FETCH, 1'b1, OP_R_TYPE);
    push(S_DECODE, 1'b1, OP_R_TYPE);
    push(S_EXEC, 1'b1, OP_JUNK);
    push(S_R_DONE, 1'b1, OP_JUNK);
    while (sb.size() != 0) begin
      c = sb.pop_front();
      @(negedge clk); bus.mem_ready = c.mr; bus.opcode = c.op; #1;
      tests++;
      if (observed() !== c.exp) begin
        fails++;
        $display("FAIL rtype st=%0d got=%h want=%h", c.st, observed(), c.exp);
      end
    end
  endtask

  task automatic test_lw_stall();
    cyc_t c;
    push(S_FETCH, 1'b1, OP_JUNK);
    push(S_DECODE, 1'b1, OP_LW);
    push(S_MEM_ADDR, 1'b1, OP_LW);
    push(S_MEM_RD, 1'b0, OP_JUNK);
    push(S_MEM_RD, 1'b0, OP_JUNK);
    push(S_MEM_RD, 1'b1, OP_JUNK);
    push(S_MEM_WB, 1'b1, OP_JUNK);
    while (sb.size() != 0) begin
      c = sb.pop_front();
      @(negedge clk); bus.mem_ready = c.mr; bus.opcode = c.op; #1;
      tests++;
      if (observed() !== c.exp) begin
        fails++;
        $display("FAIL lw st=%0d got=%h want=%h", c.st, observed(), c.exp);
      end
    end
  endtask

  task automatic test_sw();
    cyc_t c;
    push(S_FETCH, 1'b1, OP_JUNK);
    push(S_DECODE, 1'b1, OP_SW);
    push(S_MEM_ADDR, 1'b1, OP_SW);
    push(S_MEM_WR, 1'b1, OP_JUNK);
    while (sb.size() != 0) begin
      c = sb.pop_front();
      @(negedge clk); bus.mem_ready = c.mr; bus.opcode = c.op; #1;
      tests++;
      if (observed() !== c.exp) begin
        fails++;
        $display("FAIL sw st=%0d got=%h want=%h", c.st, observed(), c.exp);
      end
    end
  endtask

  task automatic test_beq();
    cyc_t c;
    bus.zero = 1'b1;
    push(S_FETCH, 1'b1, OP_JUNK);
    push(S_DECODE, 1'b1, OP_BEQ);
    push(S_BRANCH, 1'b1, OP_JUNK);
    while (sb.size() != 0) begin
      c = sb.pop_front();
      @(negedge clk); bus.mem_ready = c.mr; bus.opcode = c.op; #1;
      tests++;
      if (observed() !== c.exp) begin
        fails++;
        $display("FAIL beq st=%0d got=%h want=%h", c.st, observed(), c.exp);
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_illegal_and_jump();
    cyc_t c;
    push(S_FETCH, 1'b1, OP_JUNK);
    push(S_DECODE, 1'b1, OP_BAD);
    push(S_FETCH, 1'b1, OP_JUNK);
    push(S_DECODE, 1'b1, OP_J);
    if (JUMP_EN) push(S_JUMP, 1'b1, OP_JUNK);
    while (sb.size() != 0) begin
      c = sb.pop_front();
      @(negedge clk); bus.mem_ready = c.mr; bus.opcode = c.op; #1;
      tests++;
      if (observed() !== c.exp) begin
        fails++;
        $display("FAIL illegal_jump st=%0d got=%h want=%h", c.st, observed(), c.exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc_t c;
    push(S_FETCH, 1'b1, OP_JUNK);
    push(S_DECODE, 1'b1, OP_LW);
    push(S_MEM_ADDR, 1'b1, OP_LW);
    push(S_MEM_RD, 1'b0, OP_JUNK);
    while (sb.size() != 0) begin
      c = sb.pop_front();
      @(negedge clk); bus.mem_ready = c.mr; bus.opcode = c.op; #1;
      tests++;
      if (observed() !== c.exp) begin
        fails++;
        $display("FAIL reset_mid_pre st=%0d got=%h want=%h", c.st, observed(), c.exp);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (observed() !== 22'd0) begin
      fails++;
      $display("FAIL reset_mid_async got=%h want=%h", observed(), 22'd0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); bus.mem_ready = 1'b1; #1;
      tests++;
      if (observed() !== 22'd0) begin
        fails++;
        $display("FAIL reset_mid_hold cyc=%0d got=%h want=%h", i, observed(), 22'd0);
      end
    end
    @(negedge clk); rst_n = 1'b1; #1;
    tests++;
    if (observed() !== 22'd0) begin
      fails++;
      $display("FAIL reset_mid_release got=%h want=%h", observed(), 22'd0);
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c;
    push(S_FETCH, 1'b0, OP_JUNK);
    push(S_FETCH, 1'b1, OP_JUNK);
    push(S_DECODE, 1'b1, OP_R_TYPE);
    push(S_EXEC, 1'b1, OP_JUNK);
    push(S_R_DONE, 1'b1, OP_JUNK);
    push(S_FETCH, 1'b1, OP_JUNK);
    push(S_DECODE, 1'b1, OP_SW);
    push(S_MEM_ADDR, 1'b1, OP_SW);
    push(S_MEM_WR, 1'b0, OP_JUNK);
    push(S_MEM_WR, 1'b1, OP_JUNK);
    push(S_FETCH, 1'b1, OP_JUNK);
    push(S_DECODE, 1'b1, OP_BEQ);
    push(S_BRANCH, 1'b1, OP_JUNK);
    push(S_FETCH, 1'b0, OP_JUNK);
    while (sb.size() != 0) begin
      c = sb.pop_front();
      @(negedge clk); bus.mem_ready = c.mr; bus.opcode = c.op; #1;
      tests++;
      if (observed() !== c.exp) begin
        fails++;
        $display("FAIL b2b st=%0d got=%h want=%h", c.st, observed(), c.exp);
      end
    end
  endtask

  initial begin
    bus.opcode    = OP_R_TYPE;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw();
    test_beq();
    test_illegal_and_jump();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
